// File: rtl/contador_modulo_param_pkg.sv
// Shared definitions for the parametrised modulo counter: terminal-mode encodings
// and the Morse timing lengths (in dot units) that the transmitter instantiates.
package contador_modulo_param_pkg;

   localparam logic [1:0] MODO_WRAP    = 2'b00;
   localparam logic [1:0] MODO_SAT     = 2'b01;
   localparam logic [1:0] MODO_ONESHOT = 2'b10;

   localparam int PUNTO    = 1;
   localparam int RAYA     = 3;
   localparam int GAP_SIMB = 1;
   localparam int GAP_CAR  = 3;
   localparam int GAP_PAL  = 7;

   // True when the mode holds the count at the terminal value instead of wrapping.
   function automatic logic modo_retiene(input logic [1:0] mode);
      return (mode == MODO_SAT) || (mode == MODO_ONESHOT);
   endfunction

endpackage

// File: rtl/contador_if.sv
// Control/status bundle of one counter block; master drives controls, slave is the counter.
interface contador_if #(parameter int WIDTH = 4);

   logic             en;
   logic             up;
   logic [1:0]       mode;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] cuenta;
   logic             tc;
   logic             wrap;
   logic             done;

   modport master (output en, up, mode, clr, load, load_val,
                   input  cuenta, tc, wrap, done);
   modport slave  (input  en, up, mode, clr, load, load_val,
                   output cuenta, tc, wrap, done);

endinterface

// File: rtl/contador_modulo_param_siguiente.sv
// Next-state logic of the counter: step, terminal detection and wrap event.
// Arithmetic is done one bit wider than the count so nothing can overflow before clamping.
module contador_siguiente
   import contador_modulo_param_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int MODULO = 12
) (
   input  logic [WIDTH-1:0] cuenta,
   input  logic             up,
   input  logic [1:0]       mode,
   input  logic             done,
   output logic [WIDTH-1:0] siguiente,
   output logic             at_terminal,
   output logic             wrap_evt
);

   localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULO - 1);

   logic [WIDTH:0] ext;
   logic [WIDTH:0] raw;

   assign ext         = {1'b0, cuenta};
   assign at_terminal = up ? (ext == MAX) : (ext == '0);
   assign wrap_evt    = at_terminal & ~done & ~modo_retiene(mode);

   always_comb begin
      raw = ext;
      if (done) begin
         raw = ext;
      end else if (at_terminal) begin
         if (!modo_retiene(mode)) raw = up ? '0 : MAX;
      end else begin
         raw = up ? ext + 1'b1 : ext - 1'b1;
      end
   end

   assign siguiente = (raw > MAX) ? MAX[WIDTH-1:0] : raw[WIDTH-1:0];

endmodule

// File: rtl/contador_modulo_param.sv
// Modulo-N up/down counter with wrap/saturate/one-shot terminal modes.
// Holds only the count/WRAP/DONE registers and the CLR > LOAD > step priority.
module contador_modulo_param
   import contador_modulo_param_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int MODULO = 12
) (
   input logic       clk,
   input logic       rst_n,
   contador_if.slave bus
);

   if (WIDTH < 1 || WIDTH > 16 || MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_param_chk
      $error("contador_modulo_param: illegal WIDTH=%0d / MODULO=%0d", WIDTH, MODULO);
   end

   localparam logic [WIDTH:0] MAX   = (WIDTH+1)'(MODULO - 1);
   localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULO);

   logic [WIDTH-1:0] cuenta;
   logic             wrap;
   logic             done;
   logic [WIDTH-1:0] siguiente;
   logic             at_terminal;
   logic             wrap_evt;
   logic [WIDTH-1:0] carga;

   contador_siguiente #(.WIDTH(WIDTH), .MODULO(MODULO)) u_sig (
      .cuenta      (cuenta),
      .up          (bus.up),
      .mode        (bus.mode),
      .done        (done),
      .siguiente   (siguiente),
      .at_terminal (at_terminal),
      .wrap_evt    (wrap_evt)
   );

   assign carga = ({1'b0, bus.load_val} >= MOD_W) ? MAX[WIDTH-1:0] : bus.load_val;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cuenta <= '0;
         wrap   <= 1'b0;
         done   <= 1'b0;
      end else if (bus.clr) begin
         cuenta <= '0;
         wrap   <= 1'b0;
         done   <= 1'b0;
      end else if (bus.load) begin
         cuenta <= carga;
         wrap   <= 1'b0;
         done   <= 1'b0;
      end else if (bus.en && !done) begin
         cuenta <= siguiente;
         wrap   <= wrap_evt;
         done   <= at_terminal && (bus.mode == MODO_ONESHOT);
      end else begin
         wrap   <= 1'b0;
      end
   end

   // Carry-out is combinational so a cascaded block steps on the same edge.
   assign bus.tc     = bus.en & at_terminal & ~done & ~bus.clr & ~bus.load;
   assign bus.cuenta = cuenta;
   assign bus.wrap   = wrap;
   assign bus.done   = done;

endmodule

// File: tb/tb_contador_modulo_param.sv
// Directed bench: a MODULO=12 counter cascaded into a MODULO=5 counter through TC/EN.
module tb_contador_modulo_param;

   logic clk;
   logic rst_n;
   int   n_chk  = 0;
   int   n_fail = 0;

   contador_if #(.WIDTH(4)) b0 ();
   contador_if #(.WIDTH(4)) b1 ();

   contador_modulo_param #(.WIDTH(4), .MODULO(12)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   contador_modulo_param #(.WIDTH(4), .MODULO(5))  u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

   assign b1.en = b0.tc;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int e;
      rst_n       = 1'b0;
      b0.up       = 1'b1;
      b0.mode     = 2'b00;
      b0.en       = 1'b0;
      b0.clr      = 1'b0;
      b0.load     = 1'b0;
      b0.load_val = '0;
      b1.up       = 1'b1;
      b1.mode     = 2'b00;
      b1.clr      = 1'b0;
      b1.load     = 1'b0;
      b1.load_val = '0;
      #1;
      chk("rst_cuenta", 32'(b0.cuenta), 0);
      chk("rst_wrap",   32'(b0.wrap),   0);
      chk("rst_done",   32'(b0.done),   0);
      chk("rst_tc",     32'(b0.tc),     0);
      #2 rst_n = 1'b1;

      // wrap, up: 0..11 then back to 0 with a one-cycle WRAP
      b0.en = 1'b1;
      for (int i = 0; i <= 12; i++) begin
         chk("t1_cuenta", 32'(b0.cuenta), 32'(i % 12));
         chk("t1_tc",     32'(b0.tc),     32'(i == 11));
         chk("t1_wrap",   32'(b0.wrap),   32'(i == 12));
         if (i < 12) step();
      end

      // down + saturate from a load of 3
      b0.load = 1'b1; b0.load_val = 4'd3; b0.up = 1'b0; b0.mode = 2'b01;
      chk("t2_tc_load", 32'(b0.tc), 0);
      step();
      b0.load = 1'b0;
      for (int i = 0; i < 6; i++) begin
         e = (3 - i > 0) ? 3 - i : 0;
         chk("t2_cuenta", 32'(b0.cuenta), 32'(e));
         chk("t2_tc",     32'(b0.tc),     32'(e == 0));
         chk("t2_wrap",   32'(b0.wrap),   0);
         step();
      end

      // one-shot up from 0
      b0.clr = 1'b1;
      step();
      b0.clr = 1'b0; b0.mode = 2'b10; b0.up = 1'b1;
      chk("t3_clr", 32'(b0.cuenta), 0);
      for (int i = 0; i < 11; i++) step();
      chk("t3_at11",   32'(b0.cuenta), 11);
      chk("t3_tc11",   32'(b0.tc),     1);
      chk("t3_done0",  32'(b0.done),   0);
      step();
      chk("t3_hold",   32'(b0.cuenta), 11);
      chk("t3_done",   32'(b0.done),   1);
      chk("t3_tcdone", 32'(b0.tc),     0);
      chk("t3_wrap",   32'(b0.wrap),   0);
      step();
      chk("t3_hold2",  32'(b0.cuenta), 11);
      chk("t3_done2",  32'(b0.done),   1);
      b0.load = 1'b1; b0.load_val = 4'd5;
      step();
      b0.load = 1'b0;
      chk("t3_load5",  32'(b0.cuenta), 5);
      chk("t3_ddone",  32'(b0.done),   0);
      step();
      chk("t3_run6",   32'(b0.cuenta), 6);

      // priority and load clamp
      b0.clr = 1'b1; b0.load = 1'b1; b0.load_val = 4'd9;
      chk("t4_tc_clr", 32'(b0.tc), 0);
      step();
      chk("t4_clr_pri", 32'(b0.cuenta), 0);
      b0.clr = 1'b0; b0.load_val = 4'd15;
      step();
      chk("t4_clamp15", 32'(b0.cuenta), 11);
      b0.load_val = 4'd12;
      step();
      chk("t4_clamp12", 32'(b0.cuenta), 11);
      b0.load_val = 4'd10;
      step();
      chk("t4_load10",  32'(b0.cuenta), 10);
      b0.load = 1'b0;

      // asynchronous reset between edges at count 7
      b0.mode = 2'b00; b0.clr = 1'b1;
      step();
      b0.clr = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk("t5_at7", 32'(b0.cuenta), 7);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_cuenta", 32'(b0.cuenta), 0);
      chk("t5_wrap",   32'(b0.wrap),   0);
      chk("t5_done",   32'(b0.done),   0);
      step();
      #2 rst_n = 1'b1;
      chk("t5_held", 32'(b0.cuenta), 0);
      step();
      chk("t5_first", 32'(b0.cuenta), 1);

      // cascade 12 x 5 = 60
      b0.clr = 1'b1; b1.clr = 1'b1;
      step();
      b0.clr = 1'b0; b1.clr = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         if (n == 60) begin
            chk("t6_tc0_59", 32'(b0.tc), 1);
            chk("t6_tc1_59", 32'(b1.tc), 1);
         end
         step();
         chk("t6_c1", 32'(b1.cuenta), 32'((n / 12) % 5));
         if (n == 59) chk("t6_c0_59", 32'(b0.cuenta), 11);
      end
      chk("t6_c0_60",   32'(b0.cuenta), 0);
      chk("t6_wrap0",   32'(b0.wrap),   1);
      chk("t6_wrap1",   32'(b1.wrap),   1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
